// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: synchronizes an SPI-like sclk/sdin/sen bus into clk
// and emits each correctly sized frame as a parallel word with a one-cycle valid.
module s2p_rx #(
  parameter int DATA_BITS = 16,
  parameter int DIR       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sdin,
  input  logic                 sen,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] FULL = 6'(DATA_BITS);
  localparam logic [5:0] CAP  = 6'(DATA_BITS + 1);

  state_t                 state, state_nxt;
  logic                   sclk_p0, sclk_s, sclk_q;
  logic                   sdin_p0, sdin_s;
  logic                   sen_p0, sen_s;
  logic                   rise;
  logic [5:0]             cnt;
  logic [DATA_BITS-1:0]   sreg;

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c >= CAP) ? CAP : c + 6'd1;
  endfunction

  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] s,
                                                   input logic b);
    if (DIR == 0) return {s[DATA_BITS-2:0], b};
    else          return {b, s[DATA_BITS-1:1]};
  endfunction

  // Input synchronizers; reset to the bus idle levels so no false edge follows reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0 <= 1'b1;
      sclk_s  <= 1'b1;
      sclk_q  <= 1'b1;
      sdin_p0 <= 1'b0;
      sdin_s  <= 1'b0;
      sen_p0  <= 1'b1;
      sen_s   <= 1'b1;
    end else begin
      sclk_p0 <= sclk;
      sclk_s  <= sclk_p0;
      sclk_q  <= sclk_s;
      sdin_p0 <= sdin;
      sdin_s  <= sdin_p0;
      sen_p0  <= sen;
      sen_s   <= sen_p0;
    end
  end

  assign rise = sclk_s & ~sclk_q;
  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sen_s) state_nxt = SHIFT;
      SHIFT:   if (sen_s)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; an sclk edge coinciding with sen_s rising is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sreg      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sen_s) begin
            cnt  <= '0;
            sreg <= '0;
          end
        end
        SHIFT: begin
          if (!sen_s && rise) begin
            if (cnt < FULL) sreg <= shift_in(sreg, sdin_s);
            cnt <= sat_inc(cnt);
          end
        end
        DONE: begin
          if (cnt == FULL) begin
            data  <= sreg;
            valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx: MSB-first and LSB-first instances share one serial bus.
module tb_s2p_rx;

  logic        clk = 1'b0;
  logic        rst, sclk, sdin, sen;
  logic [15:0] data0, data1;
  logic        valid0, valid1, err0, err1, busy0, busy1;

  int nvec = 0;
  int nfail = 0;
  int vcnt0 = 0, ecnt0 = 0, vcnt1 = 0, ecnt1 = 0, both0 = 0;
  logic [15:0] vlog0 [0:63];

  always #5 clk = ~clk;

  s2p_rx #(.DATA_BITS(16), .DIR(0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sen(sen),
    .data(data0), .valid(valid0), .frame_err(err0), .busy(busy0));

  s2p_rx #(.DATA_BITS(16), .DIR(1)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .sen(sen),
    .data(data1), .valid(valid1), .frame_err(err1), .busy(busy1));

  always @(negedge clk) begin
    if (valid0) begin
      vlog0[vcnt0 % 64] = data0;
      vcnt0++;
    end
    if (err0) ecnt0++;
    if (valid0 && err0) both0++;
    if (valid1) vcnt1++;
    if (err1) ecnt1++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits, input int msb_first,
                           input int half);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdin = msb_first ? word[nbits-1-i] : word[i];
      clks(half);
      sclk = 1'b1;
      clks(half);
    end
  endtask

  task automatic frame(input logic [31:0] word, input int nbits, input int msb_first,
                       input int half, input int gap);
    sen = 1'b0;
    clks(3);
    send_bits(word, nbits, msb_first, half);
    clks(2);
    sen = 1'b1;
    clks(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; sclk = 1'b1; sdin = 1'b0; sen = 1'b1;
    clks(3);
    nvec++; if (data0 !== 16'h0000) begin nfail++; $display("FAIL reset_data got %h want 0000", data0); end
    nvec++; if (valid0 !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", valid0); end
    nvec++; if (err0 !== 1'b0) begin nfail++; $display("FAIL reset_err got %b want 0", err0); end
    nvec++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy0); end
    rst = 1'b0;
    clks(3);
  endtask

  task automatic test_msb_first;
    int v0, e0;
    v0 = vcnt0; e0 = ecnt0;
    sen = 1'b0;
    clks(4);
    nvec++; if (busy0 !== 1'b1) begin nfail++; $display("FAIL busy_in_frame got %b want 1", busy0); end
    send_bits(32'hA5C3, 16, 1, 2);
    clks(2);
    sen = 1'b1;
    clks(8);
    nvec++; if (vcnt0 - v0 !== 1) begin nfail++; $display("FAIL msb_valid_pulses got %0d want 1", vcnt0 - v0); end
    nvec++; if (ecnt0 - e0 !== 0) begin nfail++; $display("FAIL msb_err_pulses got %0d want 0", ecnt0 - e0); end
    nvec++; if (data0 !== 16'hA5C3) begin nfail++; $display("FAIL msb_data got %h want a5c3", data0); end
    nvec++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL busy_after_frame got %b want 0", busy0); end
  endtask

  task automatic test_lsb_first;
    int v1;
    v1 = vcnt1;
    frame(32'hA5C3, 16, 0, 2, 8);
    nvec++; if (vcnt1 - v1 !== 1) begin nfail++; $display("FAIL lsb_valid_pulses got %0d want 1", vcnt1 - v1); end
    nvec++; if (data1 !== 16'hA5C3) begin nfail++; $display("FAIL lsb_data_dir1 got %h want a5c3", data1); end
    nvec++; if (data0 !== 16'hC3A5) begin nfail++; $display("FAIL lsb_data_dir0 got %h want c3a5", data0); end
  endtask

  task automatic test_short_frame;
    int v0, e0;
    frame(32'h1234, 16, 1, 2, 8);
    nvec++; if (data0 !== 16'h1234) begin nfail++; $display("FAIL good_1234 got %h want 1234", data0); end
    v0 = vcnt0; e0 = ecnt0;
    frame(32'h7FFF, 15, 1, 2, 8);
    nvec++; if (ecnt0 - e0 !== 1) begin nfail++; $display("FAIL short_err_pulses got %0d want 1", ecnt0 - e0); end
    nvec++; if (vcnt0 - v0 !== 0) begin nfail++; $display("FAIL short_valid_pulses got %0d want 0", vcnt0 - v0); end
    nvec++; if (data0 !== 16'h1234) begin nfail++; $display("FAIL short_data_hold got %h want 1234", data0); end
  endtask

  task automatic test_long_frame;
    int v0, e0;
    v0 = vcnt0; e0 = ecnt0;
    frame(32'h1FF, 17, 1, 2, 8);
    nvec++; if (ecnt0 - e0 !== 1) begin nfail++; $display("FAIL long_err_pulses got %0d want 1", ecnt0 - e0); end
    nvec++; if (vcnt0 - v0 !== 0) begin nfail++; $display("FAIL long_valid_pulses got %0d want 0", vcnt0 - v0); end
    nvec++; if (data0 !== 16'h1234) begin nfail++; $display("FAIL long_data_hold got %h want 1234", data0); end
  endtask

  task automatic test_zero_bits;
    int v0, e0;
    v0 = vcnt0; e0 = ecnt0;
    frame(32'h0, 0, 1, 2, 8);
    nvec++; if (ecnt0 - e0 !== 1) begin nfail++; $display("FAIL zero_err_pulses got %0d want 1", ecnt0 - e0); end
    nvec++; if (vcnt0 - v0 !== 0) begin nfail++; $display("FAIL zero_valid_pulses got %0d want 0", vcnt0 - v0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    v0 = vcnt0; e0 = ecnt0;
    sen = 1'b0;
    clks(3);
    send_bits(32'hBE, 8, 1, 2);
    rst = 1'b1;
    clks(2);
    nvec++; if (busy0 !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b want 0", busy0); end
    nvec++; if (data0 !== 16'h0000) begin nfail++; $display("FAIL rst_data got %h want 0000", data0); end
    rst = 1'b0;
    clks(3);
    nvec++; if (busy0 !== 1'b1) begin nfail++; $display("FAIL rst_restart_busy got %b want 1", busy0); end
    send_bits(32'hBEEF, 16, 1, 2);
    clks(2);
    sen = 1'b1;
    clks(8);
    nvec++; if (vcnt0 - v0 !== 1) begin nfail++; $display("FAIL rst_valid_pulses got %0d want 1", vcnt0 - v0); end
    nvec++; if (ecnt0 - e0 !== 0) begin nfail++; $display("FAIL rst_err_pulses got %0d want 0", ecnt0 - e0); end
    nvec++; if (data0 !== 16'hBEEF) begin nfail++; $display("FAIL rst_data_beef got %h want beef", data0); end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    v0 = vcnt0; e0 = ecnt0;
    frame(32'h0001, 16, 1, 2, 2);
    frame(32'h8000, 16, 1, 2, 8);
    nvec++; if (vcnt0 - v0 !== 2) begin nfail++; $display("FAIL b2b_valid_pulses got %0d want 2", vcnt0 - v0); end
    nvec++; if (ecnt0 - e0 !== 0) begin nfail++; $display("FAIL b2b_err_pulses got %0d want 0", ecnt0 - e0); end
    nvec++; if (vlog0[v0 % 64] !== 16'h0001) begin nfail++; $display("FAIL b2b_first got %h want 0001", vlog0[v0 % 64]); end
    nvec++; if (vlog0[(v0 + 1) % 64] !== 16'h8000) begin nfail++; $display("FAIL b2b_second got %h want 8000", vlog0[(v0 + 1) % 64]); end
    nvec++; if (both0 !== 0) begin nfail++; $display("FAIL valid_err_overlap got %0d want 0", both0); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_short_frame();
    test_long_frame();
    test_zero_bits();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter DATA_BITS, default 16: frame payload width in bits (range 2..32).
REQ-002 Parameter DIR, default 0: 0 = first received bit is data[DATA_BITS-1] (MSB first), 1 = first received bit is data[0] (LSB first).
REQ-003 clk  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  serial shift clock, asynchronous to clk; data valid on its rising edge; idles high.
REQ-006 sdin  input  1  serial data, asynchronous to clk.
REQ-007 sen  input  1  frame enable, active-low; low for the whole frame, high between frames.
REQ-008 data  output  DATA_BITS  last good received word; holds until the next good frame.
REQ-009 valid  output  1  one-clk pulse when data updates.
REQ-010 frame_err  output  1  one-clk pulse when a frame ends with a bit count other than DATA_BITS.
REQ-011 busy  output  1  high while a frame is in progress (state SHIFT).

Function
REQ-012 sclk, sdin and sen each pass through a 2-flop synchronizer; all decisions use the synchronized copies (sclk_s, sdin_s, sen_s), so input-to-state latency is 2 clk.
REQ-013 The sclk rising edge is detected as sclk_s=1 with the previous sclk_s=0; sclk high and low times are each at least 2 clk periods.
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 IDLE -> SHIFT when sen_s=0: bit counter cleared, shift register cleared.
REQ-016 In SHIFT, each detected sclk rising edge with sen_s=0 shifts in sdin_s and increments the counter.
REQ-017 DIR=0: sreg <= {sreg[DATA_BITS-2:0], sdin_s}; DIR=1: sreg <= {sdin_s, sreg[DATA_BITS-1:1]}.
REQ-018 The counter is a 6-bit field and saturates at DATA_BITS+1; edges past DATA_BITS do not change sreg and mark overflow.
REQ-019 SHIFT -> DONE when sen_s rises to 1.
REQ-020 If an sclk edge and the sen_s rise are detected in the same clk, sen takes priority and the edge is discarded.
REQ-021 In DONE, for one cycle: if count==DATA_BITS, then data <= sreg and valid=1 on the next clk; otherwise data holds and frame_err=1 on the next clk. DONE then moves to IDLE.
REQ-022 valid and frame_err are never high in the same cycle; each is high for exactly one cycle per frame.
REQ-023 A zero-bit frame (sen pulses low with no sclk edge) gives frame_err.
REQ-024 Frame-to-frame gap: sen high for at least 2 clk; if sen_s is already 0 when the FSM returns to IDLE, a new frame starts immediately.
REQ-025 sclk edges while in IDLE or DONE are ignored.
REQ-026 busy = (state==SHIFT).

Reset
REQ-027 On rst=1 at a clk edge: state=IDLE, counter=0, sreg=0, data=0, valid=0, frame_err=0, busy=0; synchronizer flops take their idle values (sclk 1, sen 1, sdin 0).
REQ-028 rst during a frame discards the partial frame with no valid and no frame_err. Once rst falls, a sen still held low starts a new frame from count 0.
REQ-029 rst has priority over every other event in the same cycle.

Verification
REQ-030 DATA_BITS=16, DIR=0, send 0xA5C3 MSB first, then raise sen -> exactly one valid pulse, data=0xA5C3, frame_err=0.
REQ-031 DIR=1, send 0xA5C3 LSB first -> data=0xA5C3. Then, with DIR=0, send the same bit order -> data=0xC3A5.
REQ-032 Good frame 0x1234, then a frame of 0xFFFF with only 15 edges -> frame_err pulse, data stays 0x1234, no valid.
REQ-033 Frame with 17 edges (16 bits 0x00FF, then 1) -> frame_err pulse, data unchanged.
REQ-034 rst asserted after 8 edges, sen still low, then 16 fresh edges of 0xBEEF -> single valid, data=0xBEEF.
REQ-035 Back-to-back frames 0x0001 and 0x8000 with a 2-clk sen-high gap, sclk at clk/4 -> two valid pulses with those values in order.
